// File: rtl/fft_pkg.sv
// Shared types and index math for the radix-2 DIT FFT sequencer.
package fft_pkg;

  localparam int unsigned FFT_N_POINTS_DEF = 64;
  localparam int unsigned FFT_LOG2_N_DEF   = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fft_seq_state_t;

  typedef struct packed {
    logic [31:0] idx_a;
    logic [31:0] idx_b;
    logic [31:0] tw_idx;
  } fft_pair_t;

  // Butterfly k of a stage: the two legs are 2^stage apart inside blocks of 2^(stage+1).
  function automatic fft_pair_t fft_pair_idx(input logic [31:0] k,
                                             input logic [31:0] stage,
                                             input logic [31:0] log2_n);
    logic [31:0] pos;
    fft_pair_t   p;
    pos      = k & ((32'd1 << stage) - 32'd1);
    p.idx_a  = ((k >> stage) << (stage + 32'd1)) | pos;
    p.idx_b  = p.idx_a + (32'd1 << stage);
    p.tw_idx = pos << (log2_n - 32'd1 - stage);
    return p;
  endfunction

endpackage

// File: rtl/fft_wb_pipe.sv
// Writeback delay line for {valid, idx_a, idx_b}; depth 0 is a straight wire.
module fft_wb_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_a_i,
  input  logic [IDX_W-1:0] idx_b_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_a_o,
  output logic [IDX_W-1:0] idx_b_o
);

  localparam int unsigned W = 1 + 2 * IDX_W;

  if (DEPTH == 0) begin : g_bypass
    assign {valid_o, idx_a_o, idx_b_o} = {valid_i, idx_a_i, idx_b_i};
  end else begin : g_pipe
    logic [W-1:0] pipe_q [DEPTH];

    // Falling edge, same as the register file it feeds.
    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= {valid_i, idx_a_i, idx_b_i};
        for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign {valid_o, idx_a_o, idx_b_o} = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/fft_sequencer.sv
// Load / butterfly-issue / drain / done sequencer for the in-place radix-2 FFT.
// Optional FFT_SEQ_INVERSE_EN adds inverse_i and tw_conj_o (latched on start).
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS   = FFT_N_POINTS_DEF,
  parameter int unsigned LOG2_N     = FFT_LOG2_N_DEF,
  parameter int unsigned STAGE_W    = 3,
  parameter int unsigned BF_LATENCY = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stall_i,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic               inverse_i,
  output logic               tw_conj_o,
`endif
  output logic               load_en_o,
  output logic               bf_valid_o,
  output logic [LOG2_N-1:0]  idx_a_o,
  output logic [LOG2_N-1:0]  idx_b_o,
  output logic [LOG2_N-2:0]  tw_idx_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               wb_en_o,
  output logic [LOG2_N-1:0]  wb_idx_a_o,
  output logic [LOG2_N-1:0]  wb_idx_b_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned KW = LOG2_N - 1;
  localparam logic [KW-1:0]      K_LAST     = KW'(N_POINTS / 2 - 1);
  localparam logic [STAGE_W-1:0] S_LAST     = STAGE_W'(LOG2_N - 1);
  localparam logic [2:0]         DRAIN_INIT = (BF_LATENCY > 0) ? 3'(BF_LATENCY - 1) : 3'd0;

  fft_seq_state_t     state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [2:0]         drain_q, drain_d;
  logic               bf_valid_q, bf_valid_d;
  logic [LOG2_N-1:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [KW-1:0]      tw_q, tw_d;
  logic               load_q, done_q, busy_q;
  fft_pair_t          pair_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: if (start_i) state_d = LOAD;
      LOAD: begin
        state_d = RUN;
        k_d     = '0;
        stage_d = '0;
      end
      RUN: if (bf_valid_q) begin
        if (k_q != K_LAST) begin
          k_d = k_q + KW'(1);
        end else begin
          k_d = '0;
          if (BF_LATENCY > 0) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end else if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end
      end
      // Hold off the next stage until every writeback of this one has landed.
      DRAIN: begin
        if (drain_q != 3'd0) begin
          drain_d = drain_q - 3'd1;
        end else if (stage_q == S_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          stage_d = stage_q + STAGE_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pair_d     = fft_pair_idx(32'(k_d), 32'(stage_d), 32'(LOG2_N));
    bf_valid_d = (state_d == RUN) && !stall_i;
    idx_a_d    = '0;
    idx_b_d    = '0;
    tw_d       = '0;
    if (state_d == RUN) begin
      idx_a_d = LOG2_N'(pair_d.idx_a);
      idx_b_d = LOG2_N'(pair_d.idx_b);
      tw_d    = KW'(pair_d.tw_idx);
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      k_q        <= '0;
      stage_q    <= '0;
      drain_q    <= '0;
      bf_valid_q <= 1'b0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      tw_q       <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      stage_q    <= stage_d;
      drain_q    <= drain_d;
      bf_valid_q <= bf_valid_d;
      idx_a_q    <= idx_a_d;
      idx_b_q    <= idx_b_d;
      tw_q       <= tw_d;
      load_q     <= (state_d == LOAD);
      done_q     <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
    end
  end

`ifdef FFT_SEQ_INVERSE_EN
  logic conj_q, conj_d;

  always_comb begin
    conj_d = conj_q;
    if (state_q == IDLE && start_i) conj_d = inverse_i;
    if (state_d == IDLE) conj_d = 1'b0;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conj_q <= 1'b0;
    else         conj_q <= conj_d;
  end

  assign tw_conj_o = conj_q;
`endif

  fft_wb_pipe #(
    .DEPTH (BF_LATENCY),
    .IDX_W (LOG2_N)
  ) u_wb_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (bf_valid_q),
    .idx_a_i (idx_a_q),
    .idx_b_i (idx_b_q),
    .valid_o (wb_en_o),
    .idx_a_o (wb_idx_a_o),
    .idx_b_o (wb_idx_b_o)
  );

  assign load_en_o  = load_q;
  assign bf_valid_o = bf_valid_q;
  assign idx_a_o    = idx_a_q;
  assign idx_b_o    = idx_b_q;
  assign tw_idx_o   = tw_q;
  assign stage_o    = stage_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: a 64-point latency-1 instance and an 8-point latency-0 instance.
`timescale 1ns/1ps
module tb_fft_sequencer;

  localparam int NA = 64, LA = 6, LATA = 1;
  localparam int NB = 8,  LB = 3, LATB = 0;
  localparam int NISS_A = NA / 2 * LA;

  typedef struct { int a; int b; int tw; int st; } bf_t;
  typedef bf_t bf_q_t [$];

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic rst_n;
  int   passed = 0, total = 0;
  int   stall_plan [NISS_A];

  logic start_a, stall_a, inv_a, conj_a;
  logic load_a, bfv_a, wben_a, busy_a, done_a;
  logic [5:0] ia_a, ib_a, wba_a, wbb_a;
  logic [4:0] tw_a;
  logic [2:0] st_a;

  logic start_b, stall_b, inv_b, conj_b;
  logic load_b, bfv_b, wben_b, busy_b, done_b;
  logic [2:0] ia_b, ib_b, wba_b, wbb_b;
  logic [1:0] tw_b;
  logic [2:0] st_b;

  logic [39:0] outs_a;
  logic [24:0] outs_b;
  assign outs_a = {load_a, bfv_a, ia_a, ib_a, tw_a, st_a, wben_a, wba_a, wbb_a, busy_a, done_a};
  assign outs_b = {load_b, bfv_b, ia_b, ib_b, tw_b, st_b, wben_b, wba_b, wbb_b, busy_b, done_b};

  fft_sequencer #(.N_POINTS(NA), .LOG2_N(LA), .STAGE_W(3), .BF_LATENCY(LATA)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .stall_i(stall_a),
`ifdef FFT_SEQ_INVERSE_EN
    .inverse_i(inv_a), .tw_conj_o(conj_a),
`endif
    .load_en_o(load_a), .bf_valid_o(bfv_a), .idx_a_o(ia_a), .idx_b_o(ib_a),
    .tw_idx_o(tw_a), .stage_o(st_a), .wb_en_o(wben_a), .wb_idx_a_o(wba_a),
    .wb_idx_b_o(wbb_a), .busy_o(busy_a), .done_o(done_a)
  );

  fft_sequencer #(.N_POINTS(NB), .LOG2_N(LB), .STAGE_W(3), .BF_LATENCY(LATB)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .stall_i(stall_b),
`ifdef FFT_SEQ_INVERSE_EN
    .inverse_i(inv_b), .tw_conj_o(conj_b),
`endif
    .load_en_o(load_b), .bf_valid_o(bfv_b), .idx_a_o(ia_b), .idx_b_o(ib_b),
    .tw_idx_o(tw_b), .stage_o(st_b), .wb_en_o(wben_b), .wb_idx_a_o(wba_b),
    .wb_idx_b_o(wbb_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Reference butterfly order: per stage, blocks of 2*span, legs span apart.
  function automatic bf_q_t build_pairs(input int n, input int lg);
    bf_q_t q;
    bf_t   e;
    int    span, groups;
    for (int s = 0; s < lg; s++) begin
      span   = 1 << s;
      groups = n / (2 * span);
      for (int g = 0; g < groups; g++)
        for (int j = 0; j < span; j++) begin
          e.a  = g * 2 * span + j;
          e.b  = e.a + span;
          e.tw = j * groups;
          e.st = s;
          q.push_back(e);
        end
    end
    return q;
  endfunction

  // One full run on the 64-point instance with the current stall_plan.
  task automatic run_a(input bit mid_pulse, input bit hold_start, input bit inv);
    bf_q_t exp_q;
    bf_t   e;
    bf_t   wbq [$];
    int    wb_cyc [$];
    int    d_edge, stall_tot, issues, wbs, stall_left;
    bit    stalled_prev, exp_wb;
    exp_q = build_pairs(NA, LA);
    stall_tot = 0; issues = 0; wbs = 0; stall_left = 0;
    foreach (stall_plan[i]) stall_tot += stall_plan[i];
    d_edge = 1 + LA * (NA / 2 + LATA) + stall_tot;
    @(posedge clk);
    start_a = 1'b1; inv_a = inv; stall_a = 1'b0;
    for (int n = 0; n <= d_edge + 3; n++) begin
      @(posedge clk);
      stalled_prev = stall_a;
      if (n == 0) start_a = 1'b0;
      if (mid_pulse && n == 40) start_a = 1'b1;
      if (mid_pulse && n == 41) start_a = 1'b0;
      if (hold_start && n == 60) start_a = 1'b1;

      total++;
      if (load_a !== ((n == 0) || (hold_start && n == d_edge + 2)))
        $display("FAIL load_en n=%0d got=%b", n, load_a);
      else passed++;
      total++;
      if (done_a !== (n == d_edge)) $display("FAIL done n=%0d got=%b exp_edge=%0d", n, done_a, d_edge);
      else passed++;
      total++;
      if (busy_a !== ((n <= d_edge) || (hold_start && n >= d_edge + 2)))
        $display("FAIL busy n=%0d got=%b", n, busy_a);
      else passed++;

      if (stalled_prev && exp_q.size() > 0) begin
        total++;
        if (bfv_a !== 1'b0 || ia_a !== 6'(exp_q[0].a) || ib_a !== 6'(exp_q[0].b) || tw_a !== 5'(exp_q[0].tw))
          $display("FAIL stall_freeze n=%0d got v=%b (%0d,%0d,%0d) exp v=0 (%0d,%0d,%0d)",
                   n, bfv_a, ia_a, ib_a, tw_a, exp_q[0].a, exp_q[0].b, exp_q[0].tw);
        else passed++;
      end

      if (n <= d_edge && bfv_a === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_issue n=%0d got=(%0d,%0d)", n, ia_a, ib_a);
        end else begin
          e = exp_q.pop_front();
          if (ia_a !== 6'(e.a) || ib_a !== 6'(e.b) || tw_a !== 5'(e.tw) || st_a !== 3'(e.st))
            $display("FAIL issue#%0d got=(%0d,%0d,tw%0d,s%0d) exp=(%0d,%0d,tw%0d,s%0d)",
                     issues, ia_a, ib_a, tw_a, st_a, e.a, e.b, e.tw, e.st);
          else passed++;
          wbq.push_back(e);
          wb_cyc.push_back(n + LATA);
        end
        if (issues == 0 || issues == 33 || issues == NISS_A - 1) begin
          total++;
          if ((issues == 0 && {ia_a, ib_a, tw_a} !== {6'd0, 6'd1, 5'd0}) ||
              (issues == 33 && {ia_a, ib_a, tw_a} !== {6'd1, 6'd3, 5'd16}) ||
              (issues == NISS_A - 1 && {ia_a, ib_a, tw_a} !== {6'd31, 6'd63, 5'd31}))
            $display("FAIL spot_issue#%0d got=(%0d,%0d,tw%0d)", issues, ia_a, ib_a, tw_a);
          else passed++;
        end
        if (stall_plan[issues] > 0) stall_left = stall_plan[issues];
        issues++;
      end

      exp_wb = (wb_cyc.size() > 0) && (wb_cyc[0] == n);
      total++;
      if (wben_a !== exp_wb) $display("FAIL wb_en n=%0d got=%b exp=%b", n, wben_a, exp_wb);
      else passed++;
      if (exp_wb) begin
        e = wbq.pop_front();
        void'(wb_cyc.pop_front());
        total++;
        if (wba_a !== 6'(e.a) || wbb_a !== 6'(e.b))
          $display("FAIL wb_idx n=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, wba_a, wbb_a, e.a, e.b);
        else passed++;
      end
      if (wben_a === 1'b1 && n <= d_edge) wbs++;

`ifdef FFT_SEQ_INVERSE_EN
      if (!(hold_start && n >= d_edge + 2)) begin
        total++;
        if (conj_a !== ((n <= d_edge) ? inv : 1'b0)) $display("FAIL tw_conj n=%0d got=%b", n, conj_a);
        else passed++;
      end
`endif
      inv_a   = 1'($urandom_range(0, 1));
      stall_a = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
    total++;
    if (issues != NISS_A || wbs != NISS_A)
      $display("FAIL counts issues=%0d wbs=%0d exp=%0d", issues, wbs, NISS_A);
    else passed++;
    start_a = 1'b0; stall_a = 1'b0;
  endtask

  task automatic clear_plan();
    foreach (stall_plan[i]) stall_plan[i] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (outs_a !== '0 || outs_b !== '0) $display("FAIL reset_outs got_a=%h got_b=%h", outs_a, outs_b);
    else passed++;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    total++;
    if (outs_a !== '0 || outs_b !== '0) $display("FAIL idle_outs got_a=%h got_b=%h", outs_a, outs_b);
    else passed++;
`ifdef FFT_SEQ_INVERSE_EN
    total++;
    if (conj_a !== 1'b0) $display("FAIL idle_conj got=%b", conj_a);
    else passed++;
`endif
  endtask

  task automatic test_basic();
    clear_plan();
    run_a(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    clear_plan();
    stall_plan[2 * (NA / 2) + 9] = 5;
    run_a(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_stall();
    int i;
    clear_plan();
    for (int r = 0; r < 4; r++) begin
      i = $urandom_range(0, NISS_A - 1);
      if (i % (NA / 2) == NA / 2 - 1) i--;
      stall_plan[i] = $urandom_range(1, 4);
    end
    run_a(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_midrun();
    bit hit;
    hit = 1'b0;
    clear_plan();
    @(posedge clk); start_a = 1'b1;
    @(posedge clk); start_a = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(posedge clk);
      if (bfv_a === 1'b1 && st_a === 3'd3) hit = 1'b1;
    end
    total++;
    if (!hit) $display("FAIL reach_stage3 got=timeout");
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (outs_a !== '0) $display("FAIL async_reset got=%h exp=0", outs_a);
    else passed++;
    @(posedge clk); @(posedge clk);
    rst_n = 1'b1;
    run_a(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_plan();
    run_a(1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency0();
    bf_q_t q;
    bf_t   e;
    int    issues, d;
    int    s1 [4][3];
    s1[0] = '{0, 2, 0}; s1[1] = '{1, 3, 2}; s1[2] = '{4, 6, 0}; s1[3] = '{5, 7, 2};
    q = build_pairs(NB, LB);
    issues = 0;
    d = 1 + LB * (NB / 2 + LATB);
    @(posedge clk); start_b = 1'b1;
    for (int n = 0; n <= d + 2; n++) begin
      @(posedge clk);
      if (n == 0) start_b = 1'b0;
      total++;
      if (load_b !== (n == 0) || done_b !== (n == d))
        $display("FAIL b_load_done n=%0d got load=%b done=%b", n, load_b, done_b);
      else passed++;
      total++;
      if (bfv_b !== (n >= 1 && n < d)) $display("FAIL b_no_gap n=%0d got=%b", n, bfv_b);
      else passed++;
      if (bfv_b === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (ia_b !== 3'(e.a) || ib_b !== 3'(e.b) || tw_b !== 2'(e.tw) || st_b !== 3'(e.st) ||
            wben_b !== 1'b1 || wba_b !== 3'(e.a) || wbb_b !== 3'(e.b))
          $display("FAIL b_issue#%0d got=(%0d,%0d,tw%0d,s%0d wb%b %0d,%0d) exp=(%0d,%0d,tw%0d,s%0d)",
                   issues, ia_b, ib_b, tw_b, st_b, wben_b, wba_b, wbb_b, e.a, e.b, e.tw, e.st);
        else passed++;
        if (issues >= 4 && issues < 8) begin
          total++;
          if (ia_b !== 3'(s1[issues-4][0]) || ib_b !== 3'(s1[issues-4][1]) || tw_b !== 2'(s1[issues-4][2]))
            $display("FAIL b_stage1#%0d got=(%0d,%0d,%0d)", issues - 4, ia_b, ib_b, tw_b);
          else passed++;
        end
        issues++;
      end else begin
        total++;
        if (wben_b !== 1'b0) $display("FAIL b_wb_idle n=%0d got=%b", n, wben_b);
        else passed++;
      end
    end
    total++;
    if (issues != NB / 2 * LB) $display("FAIL b_count got=%0d exp=%0d", issues, NB / 2 * LB);
    else passed++;
  endtask

  initial begin
    start_a = 1'b0; stall_a = 1'b0; inv_a = 1'b0;
    start_b = 1'b0; stall_b = 1'b0; inv_b = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_random_stall();
    test_reset_midrun();
    test_back_to_back();
    test_latency0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
